muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer for the shared multi-cycle multiply/divide unit behind the execute stage. It turns the level-held mul/div request from `ex` into a single start pulse and registers the operands for the unit. While the unit runs it raises a pipeline stall to `ctrl`, then hands the 64-bit result back to `ex` for exactly one cycle. It also aborts on flush or interrupt, reuses the previous result for a repeated identical operation (DIV→REM, MULHU→MUL pairs), and bounds every operation with a watchdog.

## Interface
- `TIMEOUT`, 64: max cycles in BUSY before forced completion; 8..255.
- `CACHE_EN`, 1: 1 enables result reuse on identical key; 0 always issues.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  mul/div request from `ex` (`muldiv_start_o`), level, held while stalled.
- `op_div_i`  in  1  0 = MUL, 1 = DIV (`mul_or_div`).
- `a_i`, `b_i`  in  32 each  operands (`muldiv_dividend_o` / `muldiv_divisor_o`).
- `a_uns_i`, `b_uns_i`  in  1 each  operand signedness, 1 = unsigned.
- `flush_i`  in  1  interrupt assert or pipeline flush.
- `unit_start_o`  out  1  one-cycle start pulse to the unit.
- `unit_abort_o`  out  1  one-cycle abort pulse to the unit.
- `unit_div_o`, `unit_a_o`, `unit_b_o`, `unit_a_uns_o`, `unit_b_uns_o`  out  1/32/32/1/1  registered operation to the unit, stable from start to done.
- `unit_done_i`  in  1  unit completion strobe.
- `unit_result_i`  in  64  unit result. Quotient or MUL-high in [63:32]; remainder or MUL-low in [31:0].
- `done_o`  out  1  result valid to `ex` (`muldiv_done`).
- `result_o`  out  64  result to `ex` (`muldiv_result_i`).
- `stall_req_o`  out  1  stall request to `ctrl`.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, BUSY, DONE.
- Key = {op_div, a, b, a_uns, b_uns}. The cache holds one key, a 64-bit result and a valid bit.
- IDLE, `req_i`=1, `flush_i`=0:
  - Cache hit (`CACHE_EN`=1, valid, key equal): load `result_o` from the cache and go to DONE.
  - Otherwise: latch the key into the `unit_*` registers, set `unit_start_o` for the next cycle, clear the watchdog, and go to BUSY.
- IDLE with `flush_i`=1: stay in IDLE; no start is issued.
- BUSY with `flush_i`=1 (wins over `unit_done_i`): pulse `unit_abort_o`, clear cache valid, discard the result, go to IDLE.
- BUSY with `unit_done_i`=1: capture `unit_result_i` into `result_o` and the cache, write the latched key, set valid, go to DONE. `unit_done_i` is honoured in any BUSY cycle, including the start cycle.
- BUSY with the watchdog at `TIMEOUT`-1 and no done:
  - Pulse `unit_abort_o` and `timeout_o`.
  - `result_o` = 0; clear cache valid.
  - Go to DONE.
- DONE: `done_o`=1 for one cycle, then go to IDLE. A flush in DONE does not alter the transition; `ex` suppresses the writeback itself.
- `unit_done_i` is ignored in IDLE and DONE.
- `stall_req_o` = (IDLE & `req_i` & ~`flush_i`) | BUSY. It is combinational and is 0 in DONE, so the stalled instruction retires in the DONE cycle.

## Timing
- Reset values:
  - State = IDLE; cache valid = 0.
  - All outputs 0, including `result_o`, the `unit_*` operand registers, `done_o`, `unit_start_o`, `unit_abort_o` and `timeout_o`.
- Reset asserted mid-operation returns to IDLE immediately. No abort pulse is issued; the unit shares the same reset.
- Miss latency, with the request first seen at cycle 0:
  - Cycle 1: `unit_start_o`.
  - Cycle 1+N: unit done (N ≥ 0).
  - Cycle 2+N: `done_o`.
  - The stall covers cycles 0..1+N.
- Hit latency: request at cycle 0 gives `done_o` at cycle 1, with one stall cycle.
- Back-to-back: a new `req_i` is accepted in the IDLE cycle directly following DONE. There is no dead cycle beyond that.
- The watchdog counts BUSY cycles starting at the start cycle. The counter is ⌈log2(TIMEOUT)⌉ bits and saturates.

## Structure
- Shared package / `yadan_defs.v`: state encodings (`MDC_IDLE`, `MDC_BUSY`, `MDC_DONE`), `MUL`/`DIV`, `Signed`/`Unsigned`, `DoubleRegBus`.
- No sub-module needed. The cache (key compare plus registers) stays inline, roughly 200 RTL lines in total.

## Test plan
- DIV `a`=100, `b`=7, signed, unit done after 5 cycles → start at cycle 1, `done_o` at cycle 7, `result_o`={32'd14, 32'd2}, stall for cycles 0..6.
- DIV then REM, same operands, back-to-back → second op hits the cache: no `unit_start_o`, `done_o` one cycle after the request, same 64-bit result.
- MULH signed `a`=0xFFFFFFFF, `b`=2, then MUL unsigned with the same values → signedness differs, so cache misses and the unit is started twice.
- Flush in the third BUSY cycle, coincident with `unit_done_i` → `unit_abort_o` pulse, no `done_o`, IDLE next, cache invalid, so the same op afterwards re-issues.
- Unit never responds, `TIMEOUT`=8 → abort and `timeout_o` at the 8th BUSY cycle, `done_o` with `result_o`=0, stall released.
- `rst` low asserted during BUSY → all outputs 0 asynchronously; after release, a request issues a fresh start (no stale cache hit).

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state codes,
// operation/signedness encodings, the double-width result bus and the
// operation key used by the single-entry result cache.
package muldiv_ctrl_pkg;

  localparam logic [1:0] MDC_IDLE = 2'd0;
  localparam logic [1:0] MDC_BUSY = 2'd1;
  localparam logic [1:0] MDC_DONE = 2'd2;

  localparam logic MUL      = 1'b0;
  localparam logic DIV      = 1'b1;
  localparam logic Signed   = 1'b0;
  localparam logic Unsigned = 1'b1;

  localparam int unsigned DoubleRegBus = 64;

  typedef logic [DoubleRegBus-1:0] dreg_bus_t;

  // Everything that determines the unit's 64-bit result.
  typedef struct packed {
    logic        op_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        a_uns;
    logic        b_uns;
  } mdc_key_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer between the execute stage and the shared multi-cycle mul/div
// unit. Converts the level request into a start pulse with registered
// operands, stalls the pipeline while the unit runs, returns the result
// for one cycle, aborts on flush or watchdog expiry, and short-circuits a
// repeated identical operation through a one-entry result cache.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        op_div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        a_uns_i,
  input  logic        b_uns_i,
  input  logic        flush_i,
  output logic        unit_start_o,
  output logic        unit_abort_o,
  output logic        unit_div_o,
  output logic [31:0] unit_a_o,
  output logic [31:0] unit_b_o,
  output logic        unit_a_uns_o,
  output logic        unit_b_uns_o,
  input  logic        unit_done_i,
  input  logic [63:0] unit_result_i,
  output logic        done_o,
  output logic [63:0] result_o,
  output logic        stall_req_o,
  output logic        timeout_o
);

  localparam int unsigned   CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  mdc_key_t      key_in;
  mdc_key_t      cache_key;
  dreg_bus_t     cache_res;
  logic          cache_vld;
  logic [CW-1:0] wd_cnt;

  logic in_idle;
  logic in_busy;
  logic accept;
  logic hit;
  logic wd_fire;

  assign key_in = '{op_div: op_div_i, a: a_i, b: b_i, a_uns: a_uns_i, b_uns: b_uns_i};

  assign in_idle = (state == MDC_IDLE);
  assign in_busy = (state == MDC_BUSY);
  assign accept  = in_idle && req_i && !flush_i;
  assign hit     = CACHE_EN && cache_vld && (key_in == cache_key);

  // Flush and a coincident completion both take priority over the watchdog.
  assign wd_fire = in_busy && !flush_i && !unit_done_i && (wd_cnt == WD_LAST);

  assign unit_abort_o = in_busy && (flush_i || wd_fire);
  assign timeout_o    = wd_fire;
  assign stall_req_o  = accept || in_busy;

  // Sequencing: state transitions, start/done pulses and the BUSY watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= MDC_IDLE;
      unit_start_o <= 1'b0;
      done_o       <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      unit_start_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        MDC_IDLE: begin
          if (accept) begin
            if (hit) begin
              done_o <= 1'b1;
              state  <= MDC_DONE;
            end else begin
              unit_start_o <= 1'b1;
              wd_cnt       <= '0;
              state        <= MDC_BUSY;
            end
          end
        end
        MDC_BUSY: begin
          if (flush_i) begin
            state <= MDC_IDLE;
          end else if (unit_done_i || wd_fire) begin
            done_o <= 1'b1;
            state  <= MDC_DONE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        MDC_DONE: state <= MDC_IDLE;
        default:  state <= MDC_IDLE;
      endcase
    end
  end

  // Operand registers seen by the unit; only a cache miss reloads them, so
  // they stay stable from start until the operation ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_div_o   <= MUL;
      unit_a_o     <= '0;
      unit_b_o     <= '0;
      unit_a_uns_o <= Signed;
      unit_b_uns_o <= Signed;
    end else if (accept && !hit) begin
      unit_div_o   <= op_div_i;
      unit_a_o     <= a_i;
      unit_b_o     <= b_i;
      unit_a_uns_o <= a_uns_i;
      unit_b_uns_o <= b_uns_i;
    end
  end

  // Result register and one-entry cache. A flush discards the result and a
  // watchdog expiry returns zero; both leave the cache invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o  <= '0;
      cache_res <= '0;
      cache_key <= '0;
      cache_vld <= 1'b0;
    end else begin
      if (accept && hit) begin
        result_o <= cache_res;
      end else if (in_busy) begin
        if (flush_i) begin
          cache_vld <= 1'b0;
        end else if (unit_done_i) begin
          result_o  <= unit_result_i;
          cache_res <= unit_result_i;
          cache_key <= '{op_div: unit_div_o, a: unit_a_o, b: unit_b_o,
                         a_uns: unit_a_uns_o, b_uns: unit_b_uns_o};
          cache_vld <= 1'b1;
        end else if (wd_fire) begin
          result_o  <= '0;
          cache_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. The bench plays the mul/div unit
// (fixed latency, plain-arithmetic results) and keeps a one-entry cache
// model; expectations come from the documented latencies.
module tb_muldiv_ctrl;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        a_uns = 1'b0;
  logic        b_uns = 1'b0;
  logic        flush = 1'b0;
  logic        unit_done = 1'b0;
  logic [63:0] unit_result = '0;
  logic        unit_start, unit_abort, unit_div, unit_a_uns, unit_b_uns;
  logic [31:0] unit_a, unit_b;
  logic        done, stall_req, timeout;
  logic [63:0] result;

  int checks = 0;
  int passes = 0;

  // Cache model.
  logic        m_vld = 1'b0;
  logic [69:0] m_key = '0;
  logic [63:0] m_res = '0;

  typedef struct packed {
    int          n_start;
    int          start_cyc;
    int          n_done;
    int          done_cyc;
    logic [63:0] res;
    int          abort_cyc;
    int          to_cyc;
    logic [63:0] stall;
    logic [69:0] ukey;
  } obs_t;

  always #5 clk = ~clk;

  muldiv_ctrl #(.TIMEOUT(T), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_i(req), .op_div_i(op_div),
    .a_i(a_in), .b_i(b_in), .a_uns_i(a_uns), .b_uns_i(b_uns),
    .flush_i(flush),
    .unit_start_o(unit_start), .unit_abort_o(unit_abort),
    .unit_div_o(unit_div), .unit_a_o(unit_a), .unit_b_o(unit_b),
    .unit_a_uns_o(unit_a_uns), .unit_b_uns_o(unit_b_uns),
    .unit_done_i(unit_done), .unit_result_i(unit_result),
    .done_o(done), .result_o(result), .stall_req_o(stall_req),
    .timeout_o(timeout)
  );

  // Unit behaviour: DIV gives {quotient, remainder}, MUL gives the full product.
  function automatic logic [63:0] ref_result(input logic d, input logic [31:0] a,
                                             input logic [31:0] b, input logic au,
                                             input logic bu);
    logic [63:0] sa, sb;
    logic [31:0] q, r;
    if (!d) begin
      sa = au ? {32'b0, a} : {{32{a[31]}}, a};
      sb = bu ? {32'b0, b} : {{32{b[31]}}, b};
      return sa * sb;
    end
    if (b == 32'd0) begin
      q = '1; r = a;
    end else if (au || bu) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0;
    end else begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  task automatic model_store(input logic [69:0] k, input logic [63:0] r);
    m_vld = 1'b1; m_key = k; m_res = r;
  endtask

  // Drives one request (cycle 0 = first request cycle). n = unit latency after
  // start (-1: never answers), fl = cycle carrying flush (-1: none).
  task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic au, input logic bu, input int n, input int fl,
                        output obs_t o);
    bit fin = 1'b0;
    o = '0;
    o.start_cyc = -1; o.done_cyc = -1; o.abort_cyc = -1; o.to_cyc = -1;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(posedge clk); #1;
      req = !(fl >= 0 && c > fl);
      op_div = d; a_in = a; b_in = b; a_uns = au; b_uns = bu;
      flush = (c == fl);
      unit_done = (n >= 0 && c == n + 1);
      unit_result = unit_done ? ref_result(d, a, b, au, bu) : {$urandom, $urandom};
      @(negedge clk);
      if (stall_req) o.stall[c] = 1'b1;
      if (unit_start) begin
        o.n_start++; o.start_cyc = c;
        o.ukey = {unit_div, unit_a, unit_b, unit_a_uns, unit_b_uns};
      end
      if (unit_abort) o.abort_cyc = c;
      if (timeout) o.to_cyc = c;
      if (done) begin
        o.n_done++; o.done_cyc = c; o.res = result; fin = 1'b1;
      end
      if (fl >= 0 && c == fl + 1) fin = 1'b1;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      req = 1'b0; flush = 1'b0; unit_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({unit_start, unit_abort, unit_div, unit_a, unit_b, unit_a_uns, unit_b_uns,
         done, result, stall_req, timeout} !== '0)
      $display("FAIL reset_outputs: got %h, want 0",
               {unit_start, unit_abort, unit_div, unit_a, unit_b, unit_a_uns,
                unit_b_uns, done, result, stall_req, timeout});
    else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_div_basic();
    obs_t o;
    run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 5, -1, o);
    checks++;
    if (o.n_start !== 1 || o.start_cyc !== 1)
      $display("FAIL div_start: got n=%0d cyc=%0d, want n=1 cyc=1", o.n_start, o.start_cyc);
    else passes++;
    checks++;
    if (o.ukey !== {1'b1, 32'd100, 32'd7, 1'b0, 1'b0})
      $display("FAIL div_operands: got %h, want %h", o.ukey, {1'b1, 32'd100, 32'd7, 2'b00});
    else passes++;
    checks++;
    if (o.done_cyc !== 7) $display("FAIL div_done_cyc: got %0d, want 7", o.done_cyc);
    else passes++;
    checks++;
    if (o.res !== {32'd14, 32'd2}) $display("FAIL div_result: got %h, want %h", o.res, {32'd14, 32'd2});
    else passes++;
    checks++;
    if (o.stall !== 64'h7F) $display("FAIL div_stall: got %h, want 7f", o.stall);
    else passes++;
    model_store({1'b1, 32'd100, 32'd7, 2'b00}, {32'd14, 32'd2});
  endtask

  // REM after DIV with identical operands, issued in the cycle after DONE.
  task automatic test_back_to_back_hit();
    obs_t o;
    run_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 0, -1, o);
    checks++;
    if (o.n_start !== 0) $display("FAIL hit_no_start: got %0d starts, want 0", o.n_start);
    else passes++;
    checks++;
    if (o.done_cyc !== 1) $display("FAIL hit_done_cyc: got %0d, want 1", o.done_cyc);
    else passes++;
    checks++;
    if (o.res !== {32'd14, 32'd2}) $display("FAIL hit_result: got %h, want %h", o.res, {32'd14, 32'd2});
    else passes++;
    checks++;
    if (o.stall !== 64'h1) $display("FAIL hit_stall: got %h, want 1", o.stall);
    else passes++;
  endtask

  task automatic test_sign_miss();
    obs_t o1, o2;
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 3, -1, o1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 1, -1, o2);
    checks++;
    if (o1.n_start !== 1 || o2.n_start !== 1)
      $display("FAIL sign_starts: got %0d,%0d, want 1,1", o1.n_start, o2.n_start);
    else passes++;
    checks++;
    if (o1.res !== 64'hFFFF_FFFF_FFFF_FFFE || o1.done_cyc !== 5)
      $display("FAIL mulh_signed: got %h @%0d, want fffffffffffffffe @5", o1.res, o1.done_cyc);
    else passes++;
    checks++;
    if (o2.res !== 64'h0000_0001_FFFF_FFFE || o2.done_cyc !== 3)
      $display("FAIL mul_unsigned: got %h @%0d, want 00000001fffffffe @3", o2.res, o2.done_cyc);
    else passes++;
    model_store({1'b0, 32'hFFFF_FFFF, 32'd2, 2'b11}, 64'h0000_0001_FFFF_FFFE);
  endtask

  task automatic test_flush();
    obs_t o;
    // Flush while IDLE: no stall, no start.
    @(posedge clk); #1;
    req = 1'b1; flush = 1'b1; op_div = 1'b0; a_in = 32'd5; b_in = 32'd6;
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0) $display("FAIL flush_idle_stall: got %b, want 0", stall_req);
    else passes++;
    idle(1);
    checks++;
    if (unit_start !== 1'b0) $display("FAIL flush_idle_start: got %b, want 0", unit_start);
    else passes++;
    // Flush in the third BUSY cycle, coincident with unit done.
    run_op(1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0, 2, 3, o);
    checks++;
    if (o.abort_cyc !== 3 || o.n_done !== 0)
      $display("FAIL flush_busy: got abort@%0d done=%0d, want abort@3 done=0", o.abort_cyc, o.n_done);
    else passes++;
    checks++;
    if (o.stall !== 64'hF) $display("FAIL flush_stall: got %h, want f", o.stall);
    else passes++;
    m_vld = 1'b0;
    // The previously cached op must now be issued to the unit again.
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 0, -1, o);
    checks++;
    if (o.n_start !== 1 || o.done_cyc !== 2 || o.res !== 64'h0000_0001_FFFF_FFFE)
      $display("FAIL flush_reissue: got n=%0d @%0d %h, want n=1 @2 00000001fffffffe",
               o.n_start, o.done_cyc, o.res);
    else passes++;
    model_store({1'b0, 32'hFFFF_FFFF, 32'd2, 2'b11}, 64'h0000_0001_FFFF_FFFE);
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [63:0] r;
    r = ref_result(1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1);
    idle(2);
    run_op(1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1, -1, -1, o);
    checks++;
    if (o.abort_cyc !== T || o.to_cyc !== T)
      $display("FAIL timeout_pulse: got abort@%0d to@%0d, want %0d", o.abort_cyc, o.to_cyc, T);
    else passes++;
    checks++;
    if (o.done_cyc !== T + 1 || o.res !== 64'd0)
      $display("FAIL timeout_done: got @%0d %h, want @%0d 0", o.done_cyc, o.res, T + 1);
    else passes++;
    checks++;
    if (o.stall !== 64'h1FF) $display("FAIL timeout_stall: got %h, want 1ff", o.stall);
    else passes++;
    m_vld = 1'b0;
    // Done in the last allowed BUSY cycle wins over the watchdog.
    run_op(1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1, T - 1, -1, o);
    checks++;
    if (o.n_start !== 1 || o.to_cyc !== -1 || o.done_cyc !== T + 1 || o.res !== r)
      $display("FAIL timeout_edge: got n=%0d to@%0d @%0d %h, want n=1 to@-1 @%0d %h",
               o.n_start, o.to_cyc, o.done_cyc, o.res, T + 1, r);
    else passes++;
    model_store({1'b1, 32'hDEAD, 32'd3, 2'b11}, r);
    run_op(1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1, 0, -1, o);
    checks++;
    if (o.n_start !== 0 || o.res !== r)
      $display("FAIL timeout_edge_cached: got n=%0d %h, want n=0 %h", o.n_start, o.res, r);
    else passes++;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(posedge clk); #1;
    req = 1'b1; flush = 1'b0; unit_done = 1'b0;
    op_div = 1'b1; a_in = 32'd50; b_in = 32'd3; a_uns = 1'b0; b_uns = 1'b0;
    @(posedge clk); #1;
    #2;
    rst = 1'b0; req = 1'b0;
    #1;
    checks++;
    if ({unit_start, unit_abort, unit_div, unit_a, unit_b, unit_a_uns, unit_b_uns,
         done, result, stall_req, timeout} !== '0)
      $display("FAIL reset_mid_outputs: got %h, want 0",
               {unit_start, unit_abort, unit_div, unit_a, unit_b, unit_a_uns,
                unit_b_uns, done, result, stall_req, timeout});
    else passes++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_vld = 1'b0;
    run_op(1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1, 1, -1, o);
    checks++;
    if (o.n_start !== 1 || o.done_cyc !== 3)
      $display("FAIL reset_mid_fresh: got n=%0d @%0d, want n=1 @3", o.n_start, o.done_cyc);
    else passes++;
    model_store({1'b1, 32'hDEAD, 32'd3, 2'b11}, ref_result(1'b1, 32'hDEAD, 32'd3, 1'b1, 1'b1));
  endtask

  task automatic test_random();
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic        d, au, bu, hit;
    logic [31:0] a, b;
    logic [63:0] exp_res, exp_stall;
    int          n, fl, exp_start, exp_done, exp_abort, exp_to;
    obs_t        o;
    pa = '{32'd100, 32'hFFFF_FFFF, $urandom, $urandom};
    pb = '{32'd7, 32'd2, $urandom, 32'd0};
    d = 1'b0; a = '0; b = '0; au = 1'b0; bu = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 1) == 0) begin
        d  = 1'($urandom_range(0, 1));
        a  = pa[$urandom_range(0, 3)];
        b  = pb[$urandom_range(0, 3)];
        au = 1'($urandom_range(0, 1));
        bu = 1'($urandom_range(0, 1));
      end
      hit = m_vld && (m_key == {d, a, b, au, bu});
      n   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 7));
      fl  = (!hit && n >= 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n + 1)) : -1;
      exp_res = '0; exp_abort = -1; exp_to = -1;
      if (hit) begin
        exp_start = 0; exp_done = 1; exp_res = m_res; exp_stall = 64'h1;
      end else if (fl >= 0) begin
        exp_start = 1; exp_done = -1; exp_abort = fl;
        exp_stall = (64'd1 << (fl + 1)) - 64'd1;
        m_vld = 1'b0;
      end else if (n < 0) begin
        exp_start = 1; exp_done = T + 1; exp_abort = T; exp_to = T;
        exp_stall = (64'd1 << (T + 1)) - 64'd1;
        m_vld = 1'b0;
      end else begin
        exp_start = 1; exp_done = n + 2; exp_res = ref_result(d, a, b, au, bu);
        exp_stall = (64'd1 << (n + 2)) - 64'd1;
        model_store({d, a, b, au, bu}, exp_res);
      end
      run_op(d, a, b, au, bu, n, fl, o);
      checks++;
      if (o.n_start !== exp_start || o.done_cyc !== exp_done)
        $display("FAIL rnd%0d_flow: got start=%0d done@%0d, want start=%0d done@%0d",
                 i, o.n_start, o.done_cyc, exp_start, exp_done);
      else passes++;
      checks++;
      if (o.abort_cyc !== exp_abort || o.to_cyc !== exp_to || o.stall !== exp_stall)
        $display("FAIL rnd%0d_ctrl: got abort@%0d to@%0d stall=%h, want abort@%0d to@%0d stall=%h",
                 i, o.abort_cyc, o.to_cyc, o.stall, exp_abort, exp_to, exp_stall);
      else passes++;
      if (exp_done >= 0) begin
        checks++;
        if (o.res !== exp_res) $display("FAIL rnd%0d_result: got %h, want %h", i, o.res, exp_res);
        else passes++;
      end
      if (exp_start == 1) begin
        checks++;
        if (o.ukey !== {d, a, b, au, bu})
          $display("FAIL rnd%0d_operands: got %h, want %h", i, o.ukey, {d, a, b, au, bu});
        else passes++;
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_back_to_back_hit();
    test_sign_miss();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got no completion, want completion before 1ms");
    $fatal(1, "time limit");
  end

endmodule
